tms_wb_loader: RTL and testbench
================================

Name: tms_wb_loader

Overview:
- Wishbone classic initiator that boots the TMS1x00 core wrapper.
- Accepts a byte stream, such as one from an SPI or UART bridge, and packs it little-endian into 32-bit words.
- Writes each word into the wrapper's program-RAM window, with optional read-back verification.
- Finishes with one write to the wrapper control register, releasing the core.
- Sits between the boot-source bridge and the wrapper's Wishbone slave port.

Parameters:
BASE_ADDR, 32'h3001_0000, program-RAM window base (address bit 16 set)
CTRL_ADDR, 32'h3080_0000, wrapper control register (address bit 23 set)
WORDS, 512, number of 32-bit words to load (1..512)
VERIFY, 1, 1 = read back each word after writing it and compare
TIMEOUT, 16, maximum cycles to wait for wbm_ack_i per transaction

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  synchronous active-high reset
start  in  1  single-cycle pulse that begins a load; ignored while busy=1
ctrl_word  in  32  value written to CTRL_ADDR at the end; sampled on start
byte_in  in  8  stream data
byte_valid  in  1  stream data valid
byte_ready  out  1  loader accepts byte_in this cycle
wbm_adr_o  out  32  Wishbone address
wbm_dat_o  out  32  Wishbone write data
wbm_dat_i  in  32  Wishbone read data
wbm_we_o  out  1  write enable
wbm_sel_o  out  4  byte selects, always 4'hF
wbm_cyc_o  out  1  cycle
wbm_stb_o  out  1  strobe
wbm_ack_i  in  1  acknowledge
busy  out  1  load in progress
done  out  1  load finished; held until next start
error  out  1  timeout or verify mismatch; held until next start
word_idx  out  9  index of the word currently being loaded

Behaviour:
- Reset: every output is 0 except wbm_sel_o=4'hF. State goes to IDLE and all counters clear.
- Reset mid-transaction drops cyc/stb in the same cycle in which reset is sampled. No other cleanup.
- IDLE:
  - start=1 latches ctrl_word, clears done/error and word_idx, sets busy, goes to FILL.
- FILL:
  - byte_ready=1. A byte is taken when byte_valid&byte_ready.
  - Byte n of a word (n=0..3) goes to bits [8n+7:8n].
  - After the 4th byte, byte_ready drops the next cycle, then go to GAP (next=WR).
- GAP:
  - cyc/stb low; wait until wbm_ack_i=0 has been sampled for one cycle.
  - This is mandatory. The wrapper's ack is a two-stage delayed copy of cyc&stb, so it stays high after stb drops. Starting the next strobe while ack is still high would produce a false ack.
- WR:
  - Drive wbm_adr_o=BASE_ADDR+(word_idx<<2), wbm_dat_o=word, we=1, cyc=stb=1.
  - Hold until ack is sampled high, then drop cyc/stb the next cycle.
  - Next state: GAP then RD if VERIFY, otherwise ADV.
- RD:
  - Same address, we=0. Capture wbm_dat_i in the ack cycle.
  - Mismatch with the written word: error=1, go to FAIL.
  - Match: go to ADV.
- ADV:
  - word_idx==WORDS-1: go to GAP then CTRL.
  - Otherwise word_idx+1, go to FILL.
  - word_idx never wraps.
- CTRL:
  - Write the latched ctrl_word to CTRL_ADDR, same handshake as WR.
  - On ack: done=1, busy=0, back to IDLE.
- Timeout:
  - A per-transaction counter starts at 0 on the first stb cycle.
  - If it reaches TIMEOUT-1 with no ack: drop cyc/stb, error=1, go to FAIL.
- FAIL: busy=0, done=1, error=1; return to IDLE.
- Other rules:
  - start is ignored in every state except IDLE.
  - byte_valid outside FILL is ignored and no byte is consumed.
  - wbm_cyc_o==wbm_stb_o at all times.
  - Outputs are stable while stb=1 and ack=0.
- Latency with an ack that arrives 2 cycles after stb:
  - Each write takes 3 cycles of stb plus a gap of at least 2 cycles.

Test Plan:
- WORDS=2, VERIFY=0, bytes 11,22,33,44,55,66,77,88, target acks at stb+2 → writes 32'h44332211@3001_0000 and 32'h88776655@3001_0004, then ctrl_word 32'h1 @3080_0000; done=1, error=0.
- Back-to-back writes against the delayed-ack responder, with ack held 2 cycles after stb falls → no second strobe while ack=1, and exactly WORDS+1 acks are counted.
- VERIFY=1, responder returns word^32'h1 on the second read → error=1 and done=1 after word 1, with no CTRL write issued.
- Responder never acks, TIMEOUT=16 → stb high for exactly 16 cycles, then cyc/stb=0 and error=1.
- byte_valid toggling 1/0 each cycle during FILL, and start pulsed mid-load → bytes are packed correctly and the second start has no effect.
- wb_rst_i asserted while stb=1 in WR → next cycle cyc/stb/busy=0 and word_idx=0; a new start reloads from address 3001_0000.

Source files
------------

// File: rtl/tms_wb_loader.sv
// tms_wb_loader
//   Boot loader for the TMS1x00 core wrapper. Packs an incoming byte stream
//   little-endian into 32-bit words, writes each word into the wrapper's
//   program-RAM window over Wishbone classic (optionally reading it back to
//   verify), then writes ctrl_word to the wrapper control register.
//
// Ports
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   start, ctrl_word         begin a load; ctrl_word latched on start
//   byte_in/_valid/_ready    byte stream handshake (ready only in FILL)
//   wbm_*                    Wishbone classic initiator
//   busy, done, error        load status; done/error held until next start
//   word_idx                 index of the word being loaded
module tms_wb_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h3001_0000,
   parameter logic [31:0] CTRL_ADDR = 32'h3080_0000,
   parameter int unsigned WORDS     = 512,
   parameter int unsigned VERIFY    = 1,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        start,
   input  logic [31:0] ctrl_word,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   input  logic        wbm_ack_i,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [8:0]  word_idx
);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_GAP, S_WR, S_RD, S_ADV, S_CTRL, S_FAIL
   } state_t;

   localparam logic [8:0]  LAST_IDX = 9'(WORDS - 1);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   state_t      gap_nxt_q, gap_nxt_d;   // where GAP goes once ack has fallen
   logic [31:0] word_q, word_d;
   logic [31:0] ctrl_q, ctrl_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic [8:0]  idx_q, idx_d;
   logic [15:0] to_q, to_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        bus_st;

   // Strobe is a pure decode of the state flop, so a reset edge drops
   // cyc/stb immediately and outputs cannot move while waiting for ack.
   assign bus_st = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_CTRL);

   always_comb begin
      state_d    = state_q;
      gap_nxt_d  = gap_nxt_q;
      word_d     = word_q;
      ctrl_d     = ctrl_q;
      byte_cnt_d = byte_cnt_q;
      idx_d      = idx_q;
      to_d       = '0;
      done_d     = done_q;
      err_d      = err_q;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ctrl_d     = ctrl_word;
               done_d     = 1'b0;
               err_d      = 1'b0;
               idx_d      = '0;
               byte_cnt_d = '0;
               state_d    = S_FILL;
            end
         end
         S_FILL: begin
            if (byte_valid) begin
               word_d[{byte_cnt_q, 3'b000} +: 8] = byte_in;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  gap_nxt_d = S_WR;
                  state_d   = S_GAP;
               end
            end
         end
         // The slave's ack lags stb by two stages; a new strobe must not
         // start until ack has been seen low, or the stale ack completes it.
         S_GAP: begin
            if (!wbm_ack_i) state_d = gap_nxt_q;
         end
         S_WR, S_RD, S_CTRL: begin
            to_d = to_q + 16'd1;
            if (wbm_ack_i) begin
               if (state_q == S_WR) begin
                  if (VERIFY != 0) begin
                     gap_nxt_d = S_RD;
                     state_d   = S_GAP;
                  end else begin
                     state_d   = S_ADV;
                  end
               end else if (state_q == S_RD) begin
                  if (wbm_dat_i != word_q) begin
                     err_d   = 1'b1;
                     done_d  = 1'b1;
                     state_d = S_FAIL;
                  end else begin
                     state_d = S_ADV;
                  end
               end else begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end else if (to_q == TO_LAST) begin
               err_d   = 1'b1;
               done_d  = 1'b1;
               state_d = S_FAIL;
            end
         end
         S_ADV: begin
            if (idx_q == LAST_IDX) begin
               gap_nxt_d = S_CTRL;
               state_d   = S_GAP;
            end else begin
               idx_d      = idx_q + 9'd1;
               byte_cnt_d = '0;
               state_d    = S_FILL;
            end
         end
         S_FAIL: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= S_IDLE;
         gap_nxt_q  <= S_IDLE;
         word_q     <= '0;
         ctrl_q     <= '0;
         byte_cnt_q <= '0;
         idx_q      <= '0;
         to_q       <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         gap_nxt_q  <= gap_nxt_d;
         word_q     <= word_d;
         ctrl_q     <= ctrl_d;
         byte_cnt_q <= byte_cnt_d;
         idx_q      <= idx_d;
         to_q       <= to_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      wbm_adr_o = '0;
      wbm_dat_o = '0;
      if (state_q == S_CTRL) begin
         wbm_adr_o = CTRL_ADDR;
         wbm_dat_o = ctrl_q;
      end else if (state_q == S_WR || state_q == S_RD) begin
         wbm_adr_o = BASE_ADDR + {21'b0, idx_q, 2'b00};
         if (state_q == S_WR) wbm_dat_o = word_q;
      end
   end

   assign wbm_we_o   = (state_q == S_WR) || (state_q == S_CTRL);
   assign wbm_sel_o  = 4'hF;
   assign wbm_cyc_o  = bus_st;
   assign wbm_stb_o  = bus_st;
   assign byte_ready = (state_q == S_FILL);
   assign busy       = (state_q != S_IDLE) && (state_q != S_FAIL);
   assign done       = done_q;
   assign error      = err_q;
   assign word_idx   = idx_q;

endmodule

// File: tb/tb_tms_wb_loader.sv
module tb_tms_wb_loader;

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [31:0] dat;
   } txn_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // index 0: VERIFY=0 instance, index 1: VERIFY=1 instance
   logic        start [2];
   logic [31:0] ctrl_word [2];
   logic [7:0]  byte_in [2];
   logic        byte_valid [2];
   logic        byte_ready [2];
   logic [31:0] adr [2];
   logic [31:0] dat_o [2];
   logic [31:0] dat_i [2];
   logic        we [2];
   logic [3:0]  sel [2];
   logic        cyc [2];
   logic        stb [2];
   logic        ack [2];
   logic        busy [2];
   logic        done [2];
   logic        error [2];
   logic [8:0]  word_idx [2];

   logic        noack [2];
   logic        corrupt [2];
   logic        ack_p1 [2]   = '{1'b0, 1'b0};
   logic        stb_prev [2] = '{1'b0, 1'b0};
   logic [31:0] mem [2][2];
   int          nack [2] = '{0, 0};
   int          viol [2] = '{0, 0};

   txn_t exp[$];
   txn_t obs[$];
   int   errors = 0;
   int   checks = 0;

   tms_wb_loader #(.WORDS(2), .VERIFY(0), .TIMEOUT(16)) u_nv (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start[0]), .ctrl_word(ctrl_word[0]),
      .byte_in(byte_in[0]), .byte_valid(byte_valid[0]), .byte_ready(byte_ready[0]),
      .wbm_adr_o(adr[0]), .wbm_dat_o(dat_o[0]), .wbm_dat_i(dat_i[0]), .wbm_we_o(we[0]),
      .wbm_sel_o(sel[0]), .wbm_cyc_o(cyc[0]), .wbm_stb_o(stb[0]), .wbm_ack_i(ack[0]),
      .busy(busy[0]), .done(done[0]), .error(error[0]), .word_idx(word_idx[0]));

   tms_wb_loader #(.WORDS(2), .VERIFY(1), .TIMEOUT(16)) u_v (
      .wb_clk_i(clk), .wb_rst_i(rst), .start(start[1]), .ctrl_word(ctrl_word[1]),
      .byte_in(byte_in[1]), .byte_valid(byte_valid[1]), .byte_ready(byte_ready[1]),
      .wbm_adr_o(adr[1]), .wbm_dat_o(dat_o[1]), .wbm_dat_i(dat_i[1]), .wbm_we_o(we[1]),
      .wbm_sel_o(sel[1]), .wbm_cyc_o(cyc[1]), .wbm_stb_o(stb[1]), .wbm_ack_i(ack[1]),
      .busy(busy[1]), .done(done[1]), .error(error[1]), .word_idx(word_idx[1]));

   // Responder modelled on the wrapper: ack is cyc&stb delayed two stages.
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         ack_p1[g]   <= cyc[g] & stb[g] & ~noack[g];
         ack[g]      <= ack_p1[g];
         stb_prev[g] <= stb[g];
         if (stb[g] && !stb_prev[g] && ack[g]) viol[g] <= viol[g] + 1;
         if (cyc[g] && stb[g] && ack[g]) begin
            obs.push_back('{we[g], adr[g], (we[g] ? dat_o[g] : 32'h0)});
            nack[g] <= nack[g] + 1;
            if (we[g] && adr[g][31:16] == 16'h3001) mem[g][adr[g][2]] <= dat_o[g];
         end
      end
   end

   always_comb begin
      for (int g = 0; g < 2; g++)
         dat_i[g] = mem[g][adr[g][2]] ^ ((corrupt[g] && adr[g][2]) ? 32'h1 : 32'h0);
   end

   // Reference model: expected bus transactions for one load.
   function automatic void push_exp(input logic [7:0] b[$], input logic [31:0] cw,
                                    input bit vfy, input int fail_word);
      for (int w = 0; w < b.size() / 4; w++) begin
         logic [31:0] d;
         logic [31:0] a;
         d = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
         a = 32'h3001_0000 + 32'(w * 4);
         exp.push_back('{1'b1, a, d});
         if (vfy) exp.push_back('{1'b0, a, 32'h0});
         if (w == fail_word) return;
      end
      exp.push_back('{1'b1, 32'h3080_0000, cw});
   endfunction

   task automatic begin_load(input int g, input logic [31:0] cw);
      @(negedge clk);
      start[g] = 1'b1;
      ctrl_word[g] = cw;
      @(negedge clk);
      start[g] = 1'b0;
   endtask

   task automatic feed(input int g, input logic [7:0] b[$], input bit toggle,
                       input int start_at, input logic [31:0] cw2);
      int i = 0;
      int n = 0;
      bit ph = 1'b0;
      bit sent = 1'b0;
      while (i < b.size()) begin
         @(negedge clk);
         start[g] = 1'b0;
         if (!sent && i == start_at) begin
            start[g] = 1'b1;
            ctrl_word[g] = cw2;
            sent = 1'b1;
         end
         byte_valid[g] = !(toggle && ph);
         byte_in[g] = b[i];
         if (byte_valid[g] && byte_ready[g]) i++;
         ph = ~ph;
         n++;
         if (n > 400) begin
            checks++; errors++;
            $display("FAIL feed_stall got %0d bytes want %0d", i, b.size());
            break;
         end
      end
      @(negedge clk);
      byte_valid[g] = 1'b0;
      start[g] = 1'b0;
   endtask

   task automatic wait_done(input int g);
      int n = 0;
      while (!done[g] && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!done[g]) begin
         checks++; errors++;
         $display("FAIL done_timeout got done=%0d want 1", done[g]);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         checks++;
         if ({busy[g], done[g], error[g], cyc[g], stb[g], we[g], byte_ready[g]} !== 7'b0) begin
            errors++;
            $display("FAIL rst_flags dut%0d got %b want 0", g,
                     {busy[g], done[g], error[g], cyc[g], stb[g], we[g], byte_ready[g]});
         end
         checks++;
         if (sel[g] !== 4'hF) begin errors++; $display("FAIL rst_sel dut%0d got %h want f", g, sel[g]); end
         checks++;
         if (adr[g] !== 32'h0) begin errors++; $display("FAIL rst_adr dut%0d got %h want 0", g, adr[g]); end
         checks++;
         if (dat_o[g] !== 32'h0) begin errors++; $display("FAIL rst_dat dut%0d got %h want 0", g, dat_o[g]); end
         checks++;
         if (word_idx[g] !== 9'd0) begin errors++; $display("FAIL rst_idx dut%0d got %0d want 0", g, word_idx[g]); end
      end
   endtask

   task automatic cmp_status(input string nm, input int g, input logic d, input logic e);
      checks++;
      if (done[g] !== d || error[g] !== e || busy[g] !== 1'b0) begin
         errors++;
         $display("FAIL %s_status got done=%0d error=%0d busy=%0d want done=%0d error=%0d busy=0",
                  nm, done[g], error[g], busy[g], d, e);
      end
   endtask

   task automatic test_write_seq();
      logic [7:0] b[$];
      txn_t e, o;
      b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      obs.delete(); exp.delete();
      push_exp(b, 32'h1, 1'b0, -1);
      begin_load(0, 32'h1);
      feed(0, b, 1'b0, -1, 32'h0);
      wait_done(0);
      cmp_status("wrseq", 0, 1'b1, 1'b0);
      checks++;
      if (obs.size() !== exp.size()) begin
         errors++; $display("FAIL wrseq_count got %0d want %0d", obs.size(), exp.size());
      end
      while (exp.size() > 0 && obs.size() > 0) begin
         e = exp.pop_front(); o = obs.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL wrseq_txn got we=%0d adr=%h dat=%h want we=%0d adr=%h dat=%h",
                     o.we, o.adr, o.dat, e.we, e.adr, e.dat);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b[$];
      txn_t e, o;
      int a0, v0;
      for (int i = 0; i < 8; i++) b.push_back(8'($urandom_range(0, 255)));
      obs.delete(); exp.delete();
      a0 = nack[0]; v0 = viol[0];
      push_exp(b, 32'hCAFE_0001, 1'b0, -1);
      begin_load(0, 32'hCAFE_0001);
      feed(0, b, 1'b0, -1, 32'h0);
      wait_done(0);
      cmp_status("b2b", 0, 1'b1, 1'b0);
      checks++;
      if (viol[0] - v0 !== 0) begin
         errors++; $display("FAIL b2b_stb_during_ack got %0d want 0", viol[0] - v0);
      end
      checks++;
      if (nack[0] - a0 !== 3) begin
         errors++; $display("FAIL b2b_ack_count got %0d want 3", nack[0] - a0);
      end
      while (exp.size() > 0 && obs.size() > 0) begin
         e = exp.pop_front(); o = obs.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b_txn got we=%0d adr=%h dat=%h want we=%0d adr=%h dat=%h",
                     o.we, o.adr, o.dat, e.we, e.adr, e.dat);
         end
      end
   endtask

   task automatic test_verify(input bit bad);
      logic [7:0] b[$];
      txn_t e, o;
      b = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02, 8'h03, 8'h04};
      obs.delete(); exp.delete();
      corrupt[1] = bad;
      push_exp(b, 32'h5, 1'b1, bad ? 1 : -1);
      begin_load(1, 32'h5);
      feed(1, b, 1'b0, -1, 32'h0);
      wait_done(1);
      repeat (3) @(negedge clk);
      cmp_status(bad ? "vfail" : "vpass", 1, 1'b1, bad);
      if (bad) begin
         checks++;
         if (word_idx[1] !== 9'd1) begin errors++; $display("FAIL vfail_idx got %0d want 1", word_idx[1]); end
      end
      checks++;
      if (obs.size() !== exp.size()) begin
         errors++; $display("FAIL verify_count got %0d want %0d", obs.size(), exp.size());
      end
      while (exp.size() > 0 && obs.size() > 0) begin
         e = exp.pop_front(); o = obs.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL verify_txn got we=%0d adr=%h dat=%h want we=%0d adr=%h dat=%h",
                     o.we, o.adr, o.dat, e.we, e.adr, e.dat);
         end
      end
      corrupt[1] = 1'b0;
   endtask

   task automatic test_timeout();
      logic [7:0] b[$];
      int n = 0;
      int hi = 0;
      b = '{8'h01, 8'h02, 8'h03, 8'h04};
      obs.delete();
      noack[0] = 1'b1;
      begin_load(0, 32'h9);
      feed(0, b, 1'b0, -1, 32'h0);
      while (!stb[0] && n < 50) begin @(negedge clk); n++; end
      while (stb[0] && hi < 100) begin hi++; @(negedge clk); end
      checks++;
      if (hi !== 16) begin errors++; $display("FAIL to_stb_cycles got %0d want 16", hi); end
      checks++;
      if ({cyc[0], stb[0], error[0]} !== 3'b001) begin
         errors++; $display("FAIL to_drop got cyc=%0d stb=%0d error=%0d want 0 0 1", cyc[0], stb[0], error[0]);
      end
      repeat (2) @(negedge clk);
      cmp_status("to", 0, 1'b1, 1'b1);
      checks++;
      if (obs.size() !== 0) begin errors++; $display("FAIL to_acks got %0d want 0", obs.size()); end
      noack[0] = 1'b0;
   endtask

   task automatic test_toggle_start();
      logic [7:0] b[$];
      txn_t e, o;
      b = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
      obs.delete(); exp.delete();
      push_exp(b, 32'h0000_00A5, 1'b0, -1);
      begin_load(0, 32'h0000_00A5);
      feed(0, b, 1'b1, 3, 32'hDEAD_BEEF);
      wait_done(0);
      cmp_status("tog", 0, 1'b1, 1'b0);
      checks++;
      if (obs.size() !== exp.size()) begin
         errors++; $display("FAIL tog_count got %0d want %0d", obs.size(), exp.size());
      end
      while (exp.size() > 0 && obs.size() > 0) begin
         e = exp.pop_front(); o = obs.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL tog_txn got we=%0d adr=%h dat=%h want we=%0d adr=%h dat=%h",
                     o.we, o.adr, o.dat, e.we, e.adr, e.dat);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b[$];
      txn_t e, o;
      int n = 0;
      b = '{8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'h44, 8'h33, 8'h22, 8'h11};
      begin_load(0, 32'h7);
      feed(0, b, 1'b0, -1, 32'h0);
      while (!(stb[0] && adr[0] == 32'h3001_0004) && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (!stb[0]) begin errors++; $display("FAIL rmid_no_wr got stb=%0d want 1", stb[0]); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({cyc[0], stb[0], busy[0], done[0]} !== 4'b0 || word_idx[0] !== 9'd0) begin
         errors++;
         $display("FAIL rmid_state got cyc=%0d stb=%0d busy=%0d done=%0d idx=%0d want all 0",
                  cyc[0], stb[0], busy[0], done[0], word_idx[0]);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      obs.delete(); exp.delete();
      b = '{8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A, 8'h69, 8'h78};
      push_exp(b, 32'h3, 1'b0, -1);
      begin_load(0, 32'h3);
      feed(0, b, 1'b0, -1, 32'h0);
      wait_done(0);
      cmp_status("rmid", 0, 1'b1, 1'b0);
      checks++;
      if (obs.size() !== exp.size()) begin
         errors++; $display("FAIL rmid_count got %0d want %0d", obs.size(), exp.size());
      end
      while (exp.size() > 0 && obs.size() > 0) begin
         e = exp.pop_front(); o = obs.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rmid_txn got we=%0d adr=%h dat=%h want we=%0d adr=%h dat=%h",
                     o.we, o.adr, o.dat, e.we, e.adr, e.dat);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int g = 0; g < 2; g++) begin
         start[g] = 1'b0; ctrl_word[g] = '0; byte_in[g] = '0; byte_valid[g] = 1'b0;
         noack[g] = 1'b0; corrupt[g] = 1'b0;
      end
      test_reset();
      test_write_seq();
      test_back_to_back();
      test_verify(1'b0);
      test_verify(1'b1);
      test_timeout();
      test_toggle_start();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
